// File: rtl/spi_reg_pkg.sv
// Shared constants and FSM state type for the SPI register peripheral.
package spi_reg_pkg;

    localparam logic [6:0] ADDR_OUT_7_0   = 7'h00;
    localparam logic [6:0] ADDR_OUT_15_8  = 7'h01;
    localparam logic [6:0] ADDR_PWM_7_0   = 7'h02;
    localparam logic [6:0] ADDR_PWM_15_8  = 7'h03;
    localparam logic [6:0] ADDR_PWM_DUTY  = 7'h04;

    localparam int FRAME_BITS = 16;
    localparam int CNT_MAX    = FRAME_BITS + 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_t;

endpackage

// File: rtl/spi_reg_peripheral_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin with registered edge detection.
module sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              last_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_VAL}};
            last_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            last_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~last_q;
    assign fall  = ~level & last_q;

endmodule

// File: rtl/spi_reg_peripheral.sv
// SPI mode-0 write-only register slave: 16-bit frames update five 8-bit control registers.
module spi_reg_peripheral
    import spi_reg_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [6:0] MAX_ADDR    = 7'h04
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle
);

    localparam logic [4:0] CNT_FULL = 5'(FRAME_BITS);
    localparam logic [4:0] CNT_SAT  = 5'(CNT_MAX);

    logic sclk_rise, sclk_level_unused, sclk_fall_unused;
    logic copi_level, copi_rise_unused, copi_fall_unused;
    logic ncs_level, ncs_rise, ncs_fall;

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .din(sclk),
        .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall_unused)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst_n(rst_n), .din(copi),
        .level(copi_level), .rise(copi_rise_unused), .fall(copi_fall_unused)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst_n(rst_n), .din(ncs),
        .level(ncs_level), .rise(ncs_rise), .fall(ncs_fall)
    );

    state_t                  state, state_next;
    logic [FRAME_BITS-1:0]   shift_reg;
    logic [4:0]              bit_cnt;
    logic [SYNC_STAGES-1:0]  settle;
    logic                    armed;
    logic                    frame_ok;

    // The ncs synchronizer resets high, so a pin held low through reset would look like a
    // falling edge once the chain refills; only frames that begin after ncs is seen high count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            shift_reg       <= '0;
            bit_cnt         <= '0;
            settle          <= '0;
            armed           <= 1'b0;
            en_reg_out_7_0  <= 8'h00;
            en_reg_out_15_8 <= 8'h00;
            en_reg_pwm_7_0  <= 8'h00;
            en_reg_pwm_15_8 <= 8'h00;
            pwm_duty_cycle  <= 8'h00;
        end else begin
            state  <= state_next;
            settle <= {settle[SYNC_STAGES-2:0], 1'b1};
            if (settle[SYNC_STAGES-1] && ncs_level) begin
                armed <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (state_next == SHIFT) begin
                        shift_reg <= '0;
                        bit_cnt   <= '0;
                    end
                end
                SHIFT: begin
                    if (sclk_rise) begin
                        shift_reg <= {shift_reg[FRAME_BITS-2:0], copi_level};
                        if (bit_cnt != CNT_SAT) begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end
                COMMIT: begin
                    if (frame_ok) begin
                        case (shift_reg[14:8])
                            ADDR_OUT_7_0:  en_reg_out_7_0  <= shift_reg[7:0];
                            ADDR_OUT_15_8: en_reg_out_15_8 <= shift_reg[7:0];
                            ADDR_PWM_7_0:  en_reg_pwm_7_0  <= shift_reg[7:0];
                            ADDR_PWM_15_8: en_reg_pwm_15_8 <= shift_reg[7:0];
                            ADDR_PWM_DUTY: pwm_duty_cycle  <= shift_reg[7:0];
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    // A bit arriving in the same cycle as the ncs rise is shifted before COMMIT inspects the frame.
    always_comb begin
        state_next = state;
        frame_ok   = 1'b0;
        case (state)
            IDLE: begin
                if (ncs_fall && armed) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (ncs_rise) begin
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                state_next = IDLE;
                frame_ok   = (bit_cnt == CNT_FULL) && shift_reg[15] && (shift_reg[14:8] <= MAX_ADDR);
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_spi_reg_peripheral.sv
// Scoreboard bench: frames are modelled as byte writes into a register map; a monitor checks every cycle.
module tb_spi_reg_peripheral;

    localparam int         SYNC     = 2;
    localparam logic [6:0] MAX_ADDR = 7'h04;

    logic clk = 1'b0;
    logic rst_n, sclk, copi, ncs;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;

    spi_reg_peripheral #(.SYNC_STAGES(SYNC), .MAX_ADDR(MAX_ADDR)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
        .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle(pwm_duty_cycle)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [39:0] val;
    } exp_t;

    exp_t        sbq[$];
    logic [7:0]  model [0:127];
    logic [39:0] cur_exp;
    bit          mon_on = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    wire [39:0] dut_regs = {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle};

    function automatic logic [39:0] pack_model();
        return {model[0], model[1], model[2], model[3], model[4]};
    endfunction

    task automatic clear_model();
        for (int a = 0; a < 128; a++) model[a] = 8'h00;
    endtask

    task automatic push_exp(input int due, input logic [39:0] val);
        exp_t e;
        e.due = due;
        e.val = val;
        sbq.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clock_bit(input logic b);
        copi = b;
        tick(2);
        sclk = 1'b1;
        tick(4);
        sclk = 1'b0;
        tick(2);
    endtask

    // A frame is a write only when exactly 16 bits arrived, the top bit is set and the address is mapped.
    task automatic send_frame(input logic [15:0] word, input int nbits, input int gap,
                              input bit coinc, input int rst_at);
        logic b;
        int   c;
        bit   aborted;
        bit   co;
        aborted = 1'b0;
        co      = coinc && (nbits > 0);
        c       = 0;
        ncs     = 1'b0;
        tick(SYNC + 4);
        for (int i = 0; i < nbits; i++) begin
            b = (i < 16) ? word[15-i] : 1'($urandom_range(0, 1));
            if (co && i == nbits - 1) begin
                copi = b;
                tick(2);
                sclk = 1'b1;
                ncs  = 1'b1;
                c    = cyc;
                tick(4);
                sclk = 1'b0;
            end else if (i == rst_at) begin
                copi = b;
                tick(2);
                sclk  = 1'b1;
                rst_n = 1'b0;
                clear_model();
                push_exp(cyc + 1, pack_model());
                aborted = 1'b1;
                tick(2);
                rst_n = 1'b1;
                tick(2);
                sclk = 1'b0;
                tick(2);
            end else begin
                clock_bit(b);
            end
        end
        if (!co) begin
            ncs = 1'b1;
            c   = cyc;
        end
        if (!aborted && nbits == 16 && word[15] && word[14:8] <= MAX_ADDR) begin
            model[word[14:8]] = word[7:0];
        end
        push_exp(c + SYNC + 2, pack_model());
        if (co) tick((gap > 4) ? gap - 4 : 1);
        else    tick(gap);
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            while (sbq.size() > 0 && sbq[0].due <= cyc) begin
                cur_exp = sbq[0].val;
                sbq.delete(0);
            end
            n_checks++;
            if (dut_regs !== cur_exp) begin
                n_fail++;
                if (n_fail <= 20)
                    $display("FAIL reg_map cyc=%0d actual=%h required=%h", cyc, dut_regs, cur_exp);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL timeout cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [15:0] w;
        logic [6:0]  addr;
        int          nb, r, gap;
        bit          co;

        rst_n = 1'b0;
        sclk  = 1'b0;
        copi  = 1'b0;
        ncs   = 1'b1;
        clear_model();
        tick(3);
        cur_exp = '0;
        mon_on  = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(SYNC + 4);

        send_frame(16'h8055, 16, 6, 1'b0, -1);
        send_frame(16'h04F0, 16, 6, 1'b0, -1);
        send_frame(16'h8A12, 16, 6, 1'b0, -1);
        send_frame(16'h8480, 15, 6, 1'b0, -1);
        send_frame(16'h8480, 17, 6, 1'b0, -1);
        send_frame(16'h8480, 16, 6, 1'b0, -1);
        send_frame(16'h83FF, 16, 6, 1'b0, 8);
        send_frame(16'h83FF, 16, 6, 1'b0, -1);
        send_frame(16'h8001, 16, 2, 1'b0, -1);
        send_frame(16'h8102, 16, 6, 1'b0, -1);
        send_frame(16'h82A5, 16, 6, 1'b1, -1);

        // Reset released while ncs is already low: the following bits must not land.
        ncs   = 1'b0;
        rst_n = 1'b0;
        clear_model();
        push_exp(cyc + 1, pack_model());
        tick(3);
        rst_n = 1'b1;
        tick(SYNC + 4);
        w = 16'h8011;
        for (int i = 0; i < 16; i++) clock_bit(w[15-i]);
        ncs = 1'b1;
        push_exp(cyc + SYNC + 2, pack_model());
        tick(6);
        send_frame(16'h8011, 16, 6, 1'b0, -1);

        for (int k = 0; k < 40; k++) begin
            addr = ($urandom_range(0, 9) < 8) ? 7'($urandom_range(0, 4)) : 7'($urandom_range(5, 127));
            w    = {($urandom_range(0, 3) != 0), addr, 8'($urandom_range(0, 255))};
            r    = $urandom_range(0, 9);
            nb   = (r == 0) ? 15 : (r == 1) ? 17 : (r == 2) ? $urandom_range(0, 20) : 16;
            gap  = $urandom_range(2, 8);
            co   = ($urandom_range(0, 5) == 0);
            if (co && gap < 5) gap = 5;
            send_frame(w, nb, gap, co, -1);
        end

        tick(SYNC + 8);
        n_checks++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_reg_peripheral.md
SPI_REG_PERIPHERAL -- requirements
Module: spi_reg_peripheral

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: flip-flop count of each input synchronizer, minimum 2.
REQ-002 SHALL have parameter MAX_ADDR, default 7'h04: highest writable register address.
REQ-003 SHALL have port clk, input, 1: sole clock, 10 MHz nominal.
REQ-004 SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port sclk, input, 1: asynchronous SPI clock from ui_in[0].
REQ-006 SHALL have port copi, input, 1: asynchronous SPI data from ui_in[1].
REQ-007 SHALL have port ncs, input, 1: asynchronous active-low chip select from ui_in[2].
REQ-008 SHALL have port en_reg_out_7_0, output, 8: register at address 0x00.
REQ-009 SHALL have port en_reg_out_15_8, output, 8: register at address 0x01.
REQ-010 SHALL have port en_reg_pwm_7_0, output, 8: register at address 0x02.
REQ-011 SHALL have port en_reg_pwm_15_8, output, 8: register at address 0x03.
REQ-012 SHALL have port pwm_duty_cycle, output, 8: register at address 0x04.

Function
REQ-013 SHALL pass sclk, copi and ncs through SYNC_STAGES flops each, and detect edges by comparing the last stage with one further flop.
REQ-014 SHALL implement SPI mode 0: sample copi on each synchronized sclk rising edge, MSB first; falling edges are ignored.
REQ-015 SHALL frame each transaction as 16 bits: bit15 R/W (1 = write), bits14:8 address, bits7:0 data.
REQ-016 SHALL use three FSM states: IDLE, SHIFT, COMMIT.
REQ-017 IDLE->SHIFT SHALL occur on a synchronized ncs falling edge, clearing the 16-bit shift register and the 5-bit bit counter.
REQ-018 In SHIFT, each sclk rise SHALL shift in one bit; the counter increments and saturates at 17.
REQ-019 SHIFT->COMMIT SHALL occur on a synchronized ncs rising edge.
REQ-020 COMMIT SHALL last exactly one clk cycle and then return to IDLE.
REQ-021 In COMMIT, the addressed register SHALL be written only if count == 16, R/W == 1 and address <= MAX_ADDR.
REQ-022 Any other frame (short, long, read, or out-of-range address) SHALL be discarded silently with no register change.
REQ-023 The written register SHALL show the new value on the clk edge that ends COMMIT; all other registers hold their values.
REQ-024 Pin-to-output latency from ncs rise SHALL be SYNC_STAGES+2 clk cycles.
REQ-025 sclk edges while ncs is high or the FSM is in IDLE SHALL be ignored.
REQ-026 An ncs rise coincident with an sclk rise SHALL count the bit first and then evaluate the frame.
REQ-027 Outputs SHALL be driven directly from flops with no combinational path from the inputs.
REQ-028 The block SHALL support sclk up to clk/8.

Reset
REQ-029 While rst_n = 0 at a clk edge, all five registers SHALL be 8'h00, the FSM IDLE, the counter and shift register 0, and the synchronizers set to idle levels (sclk = 0, copi = 0, ncs = 1).
REQ-030 Reset mid-transaction SHALL abort the transaction with no register write.
REQ-031 After reset release with ncs already low, no bits SHALL be accepted until ncs goes high and then low again.

Structure
REQ-032 Package spi_reg_pkg SHALL hold the address constants ADDR_OUT_7_0..ADDR_PWM_DUTY (0x00..0x04), FRAME_BITS = 16, and the FSM state enum.
REQ-033 The synchronizer plus edge detector SHALL be a single sub-module, sync_edge (one instance per input), with outputs level, rise and fall.

Verification
REQ-034 After reset, frame 0x8055 written (addr 0x00, data 0x55) -> en_reg_out_7_0 = 0x55, all other registers 0x00.
REQ-035 Frame 0x04F0 (R/W = 0) -> all registers unchanged.
REQ-036 Frame 0x8A12 (addr 0x0A, beyond MAX_ADDR) -> all registers unchanged.
REQ-037 ncs raised after 15 bits of 0x8480, then again after 17 bits -> pwm_duty_cycle stays 0x00; a following clean 16-bit 0x8480 -> pwm_duty_cycle = 0x80.
REQ-038 rst_n pulsed low during bit 9 of 0x83FF -> en_reg_pwm_15_8 = 0x00, and the next clean frame 0x83FF -> 0xFF.
REQ-039 Back-to-back frames 0x8001 then 0x8102 with 2 clk cycles of ncs high between them -> en_reg_out_7_0 = 0x01 and en_reg_out_15_8 = 0x02, each updated exactly SYNC_STAGES+2 cycles after its ncs rise.
